// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one shared decryption round per clock, Nr+1 edges from accept to result.
// Round keys come from an externally expanded schedule held stable by the source.
package inv_cipher_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine map, then GF(2^8) inverse as y^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] y, t, r;
    y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    t = y;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction
endpackage

module inv_mix_col (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  import inv_cipher_pkg::*;
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_in;
  assign col_out = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                    gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                    gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                    gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
endmodule

module inv_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           ciphertext,
  input  logic [128*(Nr+1)-1:0]  key_sched,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           plaintext,
  output logic                   busy
);
  localparam int RW = $clog2(Nr);

  if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_bad_param
    $error("inv_cipher_iter: illegal Nk/Nr combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e            fsm;
  logic [RW-1:0]   rnd;
  logic [127:0]    state;
  logic [Nr:0][127:0] rk;
  logic [127:0]    sr, sb, ark, mix, nxt;

  assign rk = key_sched;

  // Byte n of the block lives at [127-8n -: 8]; row r of column c is byte 4c+r.
  always_comb begin
    sr = '0;
    sb = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = state[127-8*(4*((c-r+4)%4)+r) -: 8];
    for (int n = 0; n < 16; n++)
      sb[127-8*n -: 8] = inv_cipher_pkg::inv_sbox(sr[127-8*n -: 8]);
  end

  assign ark = sb ^ rk[rnd];

  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_col u_mix (
      .col_in  (ark[127-32*c -: 32]),
      .col_out (mix[127-32*c -: 32])
    );
  end

  assign nxt = (rnd == '0) ? ark : mix;
  assign plaintext = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      rnd       <= '0;
      state     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state    <= ciphertext ^ rk[Nr];
          rnd      <= RW'(Nr - 1);
          fsm      <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          state <= nxt;
          if (rnd == '0) begin
            fsm       <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd - 1'b1;
          end
        end
        DONE: if (out_ready) begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed bench: FIPS-197 vectors on AES-128/192/256 instances, backpressure, ignored input, reset, streaming.
module tb_inv_cipher_iter;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] iv, orr, ir, ov, bz;
  logic [127:0] ct [3];
  logic [127:0] pt [3];
  logic [128*11-1:0] ks0;
  logic [128*13-1:0] ks1;
  logic [128*15-1:0] ks2;
  int cyc = 0;
  int pass = 0, total = 0;

  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_cipher_iter #(.Nk(4), .Nr(10)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .ciphertext(ct[0]),
    .key_sched(ks0), .out_valid(ov[0]), .out_ready(orr[0]), .plaintext(pt[0]), .busy(bz[0]));
  inv_cipher_iter #(.Nk(6), .Nr(12)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .ciphertext(ct[1]),
    .key_sched(ks1), .out_valid(ov[1]), .out_ready(orr[1]), .plaintext(pt[1]), .busy(bz[1]));
  inv_cipher_iter #(.Nk(8), .Nr(14)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .ciphertext(ct[2]),
    .key_sched(ks2), .out_valid(ov[2]), .out_ready(orr[2]), .plaintext(pt[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else pass++;
  endtask

  // Forward S-box and key expansion, used only to build the key schedule stimulus.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t, y;
    t = a; y = 8'h01;
    for (int i = 0; i < 7; i++) begin t = gm(t, t); y = gm(y, t); end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [255:0] seq_key(input int nk);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < 4*nk; i++) k[255-8*i -: 8] = 8'(i);
    return k;
  endfunction
  function automatic logic [128*15-1:0] expand(input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [128*15-1:0] ks;
    int nw;
    nw = 4*(nk+7); rc = 8'h01; ks = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) ks[128*(i/4)+127-32*(i%4) -: 32] = w[i];
    return ks;
  endfunction

  // Accept one block on instance k; returns cycle stamp of the acceptance edge.
  task automatic start_op(input int k, input logic [127:0] c, input string tag, output int acc);
    int n;
    n = 0;
    while (!ir[k] && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, " ready"}, 128'(ir[k]), 128'd1);
    iv[k] = 1'b1; ct[k] = c;
    @(posedge clk); #1;
    acc = cyc;
    iv[k] = 1'b0; ct[k] = ~c;
    chk({tag, " busy"}, {125'd0, bz[k], ir[k], ov[k]}, 128'b100);
  endtask

  task automatic wait_done(input int k, input int acc, input logic [127:0] e, input int lat, input string tag);
    int n;
    n = 0;
    while (!ov[k] && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, " lat"}, 128'(cyc - acc + 1), 128'(lat));
    chk({tag, " pt"}, pt[k], e);
  endtask

  task automatic release_op(input int k, input string tag);
    orr[k] = 1'b1;
    @(posedge clk); #1;
    orr[k] = 1'b0;
    chk({tag, " idle"}, {125'd0, bz[k], ir[k], ov[k]}, 128'b010);
  endtask

  initial begin
    logic [128*15-1:0] tmp;
    int acc, seen, n;
    int t [2];
    logic [127:0] p [2];
    iv = '0; orr = '0;
    for (int i = 0; i < 3; i++) ct[i] = '0;
    tmp = expand(4, seq_key(4)); ks0 = tmp[128*11-1:0];
    tmp = expand(6, seq_key(6)); ks1 = tmp[128*13-1:0];
    tmp = expand(8, seq_key(8)); ks2 = tmp[128*15-1:0];
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst in_ready", 128'(ir[0]), 128'd1);
    chk("rst out_valid", 128'(ov[0]), 128'd0);
    chk("rst busy", 128'(bz[0]), 128'd0);
    chk("rst plaintext", pt[0], 128'd0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;

    // FIPS-197 appendix C vectors on all three key sizes
    start_op(0, CT_128, "aes128", acc); wait_done(0, acc, PT_C, 11, "aes128"); release_op(0, "aes128");
    start_op(1, CT_192, "aes192", acc); wait_done(1, acc, PT_C, 13, "aes192"); release_op(1, "aes192");
    start_op(2, CT_256, "aes256", acc); wait_done(2, acc, PT_C, 15, "aes256"); release_op(2, "aes256");

    // Backpressure: hold 20 cycles in DONE
    start_op(0, CT_128, "bp", acc); wait_done(0, acc, PT_C, 11, "bp");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp hold", {pt[0], bz[0], ir[0], ov[0]} , {PT_C, 3'b001});
    end
    release_op(0, "bp");

    // in_valid pulsed mid-RUN with a different block must be ignored
    start_op(0, CT_128, "ign", acc);
    repeat (3) begin @(posedge clk); #1; end
    iv[0] = 1'b1; ct[0] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("ign run", {125'd0, bz[0], ir[0], ov[0]}, 128'b100);
    wait_done(0, acc, PT_C, 11, "ign"); release_op(0, "ign");

    // Asynchronous reset around round 5, then appendix B vector
    start_op(0, CT_128, "mid", acc);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst flags", {125'd0, bz[0], ir[0], ov[0]}, 128'b010);
    chk("mid rst pt", pt[0], 128'd0);
    tmp = expand(4, KEY_B); ks0 = tmp[128*11-1:0];
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    start_op(0, CT_B, "postrst", acc); wait_done(0, acc, PT_B, 11, "postrst"); release_op(0, "postrst");

    // Back-to-back with out_ready tied high
    orr[0] = 1'b1; iv[0] = 1'b1; ct[0] = CT_B;
    @(posedge clk); #1;
    ct[0] = 128'h0;
    seen = 0; n = 0;
    t[0] = 0; t[1] = 0; p[0] = '0; p[1] = '0;
    while (seen < 2 && n < 60) begin
      @(posedge clk); #1; n++;
      if (ov[0]) begin
        t[seen] = cyc; p[seen] = pt[0]; seen++;
        if (seen == 1) begin
          tmp = expand(4, seq_key(4)); ks0 = tmp[128*11-1:0];
          ct[0] = CT_128;
        end else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0; orr[0] = 1'b0;
    chk("b2b count", 128'(seen), 128'd2);
    chk("b2b pt0", p[0], PT_B);
    chk("b2b pt1", p[1], PT_C);
    chk("b2b spacing", 128'(t[1] - t[0]), 128'd12);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
